// File: rtl/mode_pkg.sv
`default_nettype none
// =====================================================================
// Module   : mode_pkg
// Brief    : Shared types, mode constants and thermometer decoder for
//            the front-panel mode selector.
// Revision : 1.0
// =====================================================================
package mode_pkg;

    localparam int MAX_MODE_W  = 5;
    localparam int MAX_THERM_W = (1 << MAX_MODE_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_1   = 2'd1;
    localparam logic [1:0] MODE_2   = 2'd2;
    localparam logic [1:0] MODE_3   = 2'd3;

    // Returns {err, mode}; field is zero-extended, only the low therm_w bits matter.
    function automatic logic [MAX_MODE_W:0] therm_decode(
        input logic [MAX_THERM_W-1:0] field,
        input int                     therm_w,
        input logic [MAX_MODE_W-1:0]  default_mode
    );
        logic [MAX_MODE_W:0]    res;
        logic [MAX_THERM_W-1:0] ones;
        res  = {1'b1, default_mode};
        ones = '0;
        for (int k = 1; k <= MAX_THERM_W; k++) begin
            ones = {ones[MAX_THERM_W-2:0], 1'b1};
            if ((k <= therm_w) && (field == ones)) begin
                res = {1'b0, k[MAX_MODE_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// =====================================================================
// Module   : switch_debounce
// Brief    : Two-flop synchroniser plus whole-vector debounce counter.
// Revision : 1.0
// =====================================================================
module switch_debounce #(
    parameter int W      = 8,
    parameter int CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         vld
);

    localparam int             CNT_W     = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CYCLES - 1);

    logic [W-1:0]     r_sync1;
    logic [W-1:0]     r_sync2;
    logic [W-1:0]     r_last;
    logic [W-1:0]     r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_last   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
            // Any movement on any bit restarts the whole-vector stability window.
            if (r_sync2 != r_last) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_stable <= r_sync2;
                r_vld    <= 1'b1;
            end
        end
    end

    assign dout = r_stable;
    assign vld  = r_vld;

endmodule
`default_nettype wire

// File: rtl/mode_selector.sv
`default_nettype none
// =====================================================================
// Module   : mode_selector
// Brief    : Debounced DIP-switch front panel: LED mirror, thermometer
//            mode decode and busy-gated mode commit with change strobe.
// Revision : 1.0
// =====================================================================
module mode_selector
    import mode_pkg::*;
#(
    parameter int                SW_W            = 8,
    parameter int                MODE_W          = 2,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter logic [MODE_W-1:0] DEFAULT_MODE    = {MODE_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   dipswitch,
    input  logic              busy,
    output logic [SW_W-1:0]   led,
    output logic [MODE_W-1:0] mode,
    output logic              mode_changed,
    output logic              pattern_err,
    output logic              pending
);

    localparam int THERM_W = (1 << MODE_W) - 1;

    logic [SW_W-1:0]        w_stable;
    logic                   w_vld;
    logic [MAX_THERM_W-1:0] w_field_ext;
    logic [MAX_MODE_W-1:0]  w_default_ext;
    logic [MAX_MODE_W-1:0]  w_mode_ext;
    logic [MAX_MODE_W:0]    w_dec;
    logic                   w_err;
    logic [MODE_W-1:0]      w_target;
    logic                   w_differs;
    logic                   w_load;
    state_t                 w_next;

    state_t                 r_state;
    logic [SW_W-1:0]        r_led;
    logic [MODE_W-1:0]      r_mode;
    logic                   r_changed;
    logic                   r_err;

    switch_debounce #(
        .W      (SW_W),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dipswitch),
        .dout  (w_stable),
        .vld   (w_vld)
    );

    always_comb begin
        w_field_ext                 = '0;
        w_field_ext[THERM_W-1:0]    = w_stable[THERM_W-1:0];
        w_default_ext               = '0;
        w_default_ext[MODE_W-1:0]   = DEFAULT_MODE;
        w_mode_ext                  = '0;
        w_mode_ext[MODE_W-1:0]      = r_mode;
    end

    assign w_dec     = therm_decode(w_field_ext, THERM_W, w_default_ext);
    assign w_err     = w_dec[MAX_MODE_W];
    assign w_target  = w_dec[MODE_W-1:0];
    // Compared at full decoder width so the upper (always-zero) bits are consumed.
    assign w_differs = (w_dec[MAX_MODE_W-1:0] != w_mode_ext);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vld && w_differs) begin
                    w_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!w_differs) begin
                    w_next = ST_IDLE;
                end else if (!busy) begin
                    w_next = ST_COMMIT;
                    w_load = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_led     <= '0;
            r_mode    <= '0;
            r_changed <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_led     <= w_stable;
            r_changed <= (r_state == ST_COMMIT);
            if (w_load) begin
                r_mode <= w_target;
            end
            if (w_vld) begin
                r_err <= w_err;
            end
        end
    end

    assign led          = r_led;
    assign mode         = r_mode;
    assign mode_changed = r_changed;
    assign pattern_err  = r_err;
    assign pending      = (r_state == ST_PEND);

endmodule
`default_nettype wire

// File: tb/tb_mode_selector.sv
`default_nettype none
// =====================================================================
// Module   : tb_mode_selector
// Brief    : Scoreboard bench for mode_selector with randomized switches.
// Revision : 1.0
// =====================================================================
module tb_mode_selector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dipswitch;
    logic       busy;
    logic [7:0] led;
    logic [1:0] mode;
    logic       mode_changed;
    logic       pattern_err;
    logic       pending;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] model_mode;
    logic [1:0] exp_head;

    always #5 clk = ~clk;

    mode_selector #(
        .SW_W            (8),
        .MODE_W          (2),
        .DEBOUNCE_CYCLES (4),
        .DEFAULT_MODE    (2'b11)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dipswitch    (dipswitch),
        .busy         (busy),
        .led          (led),
        .mode         (mode),
        .mode_changed (mode_changed),
        .pattern_err  (pattern_err),
        .pending      (pending)
    );

    // Reference: count trailing ones of the 3-bit field; legal only if nothing above them.
    function automatic logic [2:0] ref_decode(input logic [7:0] sw);
        int field;
        int k;
        field = int'(sw) % 8;
        k = 0;
        while (k < 3 && ((field >> k) % 2) == 1) k++;
        if (k >= 1 && field == (1 << k) - 1) return {1'b0, 2'(k)};
        return {1'b1, 2'd3};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Switch change with busy low: expectation goes on the scoreboard immediately.
    task automatic set_sw(input logic [7:0] sw);
        logic [2:0] d;
        busy      = 1'b0;
        dipswitch = sw;
        d = ref_decode(sw);
        if (d[1:0] != model_mode) begin
            exp_q.push_back(d[1:0]);
            model_mode = d[1:0];
        end
        tick(20);
        check("led", int'(led), int'(sw));
        check("mode", int'(mode), int'(model_mode));
        check("pattern_err", int'(pattern_err), int'(d[2]));
        check("pending_idle", int'(pending), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mode_changed === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL strobe: unexpected mode_changed with mode=%0d, expected no strobe", mode);
            end else begin
                exp_head = exp_q.pop_front();
                if (mode !== exp_head) begin
                    n_errors++;
                    $display("FAIL strobe_mode: got %0d, expected %0d", mode, exp_head);
                end
            end
        end
    end

    initial begin
        logic [7:0] sw;
        logic [2:0] d;
        logic       b;

        rst_n      = 1'b0;
        busy       = 1'b0;
        dipswitch  = 8'h07;
        model_mode = 2'd0;
        tick(3);
        check("rst_led", int'(led), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_changed", int'(mode_changed), 0);
        check("rst_err", int'(pattern_err), 0);
        check("rst_pending", int'(pending), 0);

        rst_n = 1'b1;
        check("post_rst_mode", int'(mode), 0);
        set_sw(8'h07);
        set_sw(8'h03);
        set_sw(8'h07);
        set_sw(8'h05);

        // Busy held: change stays pending until busy drops.
        busy      = 1'b1;
        dipswitch = 8'h01;
        tick(100);
        check("busy_pending", int'(pending), 1);
        check("busy_mode_hold", int'(mode), 3);
        busy = 1'b0;
        exp_q.push_back(2'd1);
        model_mode = 2'd1;
        tick(2);
        check("busy_release_mode", int'(mode), 1);
        tick(10);
        check("busy_release_pending", int'(pending), 0);

        // Three-cycle glitch must be rejected.
        dipswitch = 8'h03;
        tick(3);
        dipswitch = 8'h01;
        tick(20);
        check("glitch_led", int'(led), 8'h01);
        check("glitch_mode", int'(mode), 1);

        // Reset while pending.
        busy      = 1'b1;
        dipswitch = 8'h03;
        tick(20);
        check("pend_before_rst", int'(pending), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", int'(led), 0);
        check("async_rst_mode", int'(mode), 0);
        check("async_rst_pending", int'(pending), 0);
        check("async_rst_err", int'(pattern_err), 0);
        busy       = 1'b0;
        dipswitch  = 8'h07;
        model_mode = 2'd0;
        tick(2);
        rst_n = 1'b1;
        set_sw(8'h07);

        for (int i = 0; i < 40; i++) begin
            sw = 8'($urandom);
            if ($urandom_range(0, 3) == 0) sw[2:0] = 3'($urandom_range(0, 2) == 0 ? 1 : 3);
            b = 1'($urandom_range(0, 1));
            if (!b) begin
                set_sw(sw);
            end else begin
                busy      = 1'b1;
                dipswitch = sw;
                d = ref_decode(sw);
                tick(20);
                check("rnd_led", int'(led), int'(sw));
                check("rnd_err", int'(pattern_err), int'(d[2]));
                check("rnd_mode_hold", int'(mode), int'(model_mode));
                check("rnd_pending", int'(pending), int'(d[1:0] != model_mode));
                if (d[1:0] != model_mode) begin
                    exp_q.push_back(d[1:0]);
                    model_mode = d[1:0];
                end
                busy = 1'b0;
                tick(10);
                check("rnd_mode", int'(mode), int'(model_mode));
            end
        end

        tick(20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
